// File: rtl/masked_xor_pipe_pkg.sv
// Shared definitions for the masked XOR pipeline: default geometry,
// share/randomness container types and parameter legality helper.
package masked_xor_pipe_pkg;

    localparam int unsigned DEF_NUM_SHARES = 32'd2;
    localparam int unsigned DEF_WIDTH      = 32'd8;
    localparam int unsigned DEF_LATENCY    = 32'd1;
    localparam bit          DEF_REFRESH    = 1'b1;

    // Share i of a value lives in element i of the packed array.
    typedef logic [DEF_NUM_SHARES-1:0][DEF_WIDTH-1:0] shared_t;
    // One fresh random word per share except the last.
    typedef logic [DEF_NUM_SHARES-2:0][DEF_WIDTH-1:0] random_t;

    // A masking needs at least two shares and the pipe at least one register.
    function automatic bit params_legal(input int unsigned num_shares,
                                        input int unsigned latency);
        return (num_shares >= 32'd2) && (latency >= 32'd1);
    endfunction

endpackage

// File: rtl/masked_pipe_stage.sv
// One elastic register stage: data word plus valid bit, with ready chaining
// so that an empty stage always accepts and a full one accepts only when
// its own content leaves in the same cycle.
module masked_pipe_stage
    import masked_xor_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic              dn_valid,
    input  logic              dn_ready
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;
    logic              ready_s;

    // Stage can take a word when empty or when its word is consumed now.
    always_comb begin
        ready_s = (!valid_q) || dn_ready;
    end

    // Next-state: load on upstream handover, otherwise hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (ready_s) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage register with synchronous reset clearing both data and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign up_ready = ready_s;
    assign dn_data  = data_q;
    assign dn_valid = valid_q;

endmodule

// File: rtl/masked_xor_pipe.sv
// Pipelined, handshaked sharewise masked XOR with optional share refresh.
// Stage 0 captures the (refreshed) XOR so downstream gadgets only ever see
// registered, glitch-isolated shares.
module masked_xor_pipe
    import masked_xor_pipe_pkg::*;
#(
    parameter int unsigned NUM_SHARES = DEF_NUM_SHARES,
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LATENCY    = DEF_LATENCY,
    parameter bit          REFRESH    = DEF_REFRESH
) (
    input  logic                                  in_clock,
    input  logic                                  in_reset,
    input  logic [NUM_SHARES-1:0][WIDTH-1:0]      in_a,
    input  logic [NUM_SHARES-1:0][WIDTH-1:0]      in_b,
    input  logic [NUM_SHARES-2:0][WIDTH-1:0]      in_random,
    input  logic                                  in_valid,
    output logic                                  out_ready,
    output logic [NUM_SHARES-1:0][WIDTH-1:0]      out_c,
    output logic                                  out_valid,
    input  logic                                  in_ready
);

    localparam int unsigned DATA_W    = NUM_SHARES * WIDTH;
    localparam bit          PARAMS_OK = params_legal(NUM_SHARES, LATENCY);

    if (!PARAMS_OK) begin : g_param_check
        $error("masked_xor_pipe: NUM_SHARES must be >= 2 and LATENCY >= 1");
    end

    logic [NUM_SHARES-1:0][WIDTH-1:0] x_s;
    logic [NUM_SHARES-1:0][WIDTH-1:0] c0_s;
    logic [WIDTH-1:0]                 r_sum_s;

    // Element k carries stage k's input; element LATENCY is the block output.
    logic [LATENCY:0][DATA_W-1:0]     data_s;
    logic [LATENCY:0]                 valid_s;
    logic [LATENCY:0]                 ready_s;

    // Sharewise XOR: share i only ever meets share i of the other operand.
    always_comb begin
        x_s = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            x_s[i] = in_a[i] ^ in_b[i];
        end
    end

    // Parity of all random words, folded into the last share by the refresh.
    always_comb begin
        r_sum_s = '0;
        for (int i = 0; i < NUM_SHARES - 1; i++) begin
            r_sum_s = r_sum_s ^ in_random[i];
        end
    end

    // Refresh: every r[i] enters twice overall, so the unmasked value is kept.
    always_comb begin
        c0_s = x_s;
        if (REFRESH == 1'b1) begin
            for (int i = 0; i < NUM_SHARES - 1; i++) begin
                c0_s[i] = x_s[i] ^ in_random[i];
            end
            c0_s[NUM_SHARES-1] = x_s[NUM_SHARES-1] ^ r_sum_s;
        end else begin
            c0_s = x_s;
        end
    end

    assign data_s[0]        = c0_s;
    assign valid_s[0]       = in_valid;
    assign ready_s[LATENCY] = in_ready;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        masked_pipe_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk      (in_clock),
            .rst      (in_reset),
            .up_data  (data_s[k]),
            .up_valid (valid_s[k]),
            .up_ready (ready_s[k]),
            .dn_data  (data_s[k+1]),
            .dn_valid (valid_s[k+1]),
            .dn_ready (ready_s[k+1])
        );
    end

    assign out_ready = ready_s[0];
    assign out_valid = valid_s[LATENCY];
    assign out_c     = data_s[LATENCY];

endmodule

// File: tb/tb_masked_xor_pipe.sv
// Bench for masked_xor_pipe: a 3-share refreshing 3-stage pipe under
// directed and random handshake traffic, plus a 2-share plain 1-stage pipe.
module tb_masked_xor_pipe;
    import masked_xor_pipe_pkg::*;

    localparam int unsigned NS = 32'd3;
    localparam int unsigned W  = 32'd8;
    localparam int unsigned L  = 32'd3;

    typedef logic [NS-1:0][W-1:0] m_sh_t;
    typedef logic [NS-2:0][W-1:0] m_rnd_t;

    logic   in_clock = 1'b0;
    logic   in_reset;
    m_sh_t  in_a, in_b, out_c;
    m_rnd_t in_random;
    logic   in_valid, out_ready, out_valid, in_ready;

    logic [1:0][7:0] p_a, p_b, p_c;
    logic [0:0][7:0] p_random;
    logic            p_valid, p_out_ready, p_out_valid;

    int tests = 0;
    int fails = 0;

    m_sh_t           exp_q[$];
    logic [15:0]     p_exp_q[$];
    logic            hold_chk   = 1'b0;
    m_sh_t           held_c     = '0;
    logic            fire_seen  = 1'b0;

    masked_xor_pipe #(
        .NUM_SHARES (NS), .WIDTH (W), .LATENCY (L), .REFRESH (1'b1)
    ) u_dut (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_random (in_random),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_valid (out_valid),
        .in_ready  (in_ready)
    );

    masked_xor_pipe #(
        .NUM_SHARES (32'd2), .WIDTH (32'd8), .LATENCY (32'd1), .REFRESH (1'b0)
    ) u_plain (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_a      (p_a),
        .in_b      (p_b),
        .in_random (p_random),
        .in_valid  (p_valid),
        .out_ready (p_out_ready),
        .out_c     (p_c),
        .out_valid (p_out_valid),
        .in_ready  (1'b1)
    );

    always #5 in_clock = ~in_clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shares of a^b, each r[i] added to share i and once more to the last share.
    function automatic m_sh_t ref_result(input m_sh_t a, input m_sh_t b, input m_rnd_t r);
        m_sh_t        c;
        logic [W-1:0] rs;
        rs = '0;
        for (int i = 0; i < NS; i++) c[i] = a[i] ^ b[i];
        for (int i = 0; i < NS - 1; i++) begin
            c[i] = c[i] ^ r[i];
            rs   = rs ^ r[i];
        end
        c[NS-1] = c[NS-1] ^ rs;
        return c;
    endfunction

    function automatic logic [W-1:0] unmask(input m_sh_t s);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NS; i++) v = v ^ s[i];
        return v;
    endfunction

    // Scoreboard monitor for the refreshing pipe.
    always @(negedge in_clock) begin : mon_main
        m_sh_t e;
        fire_seen = in_valid && out_ready && !in_reset;
        if (in_reset) begin
            exp_q.delete();
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("stall_hold_valid", out_valid, 1'b1);
                check("stall_hold_data", out_c, held_c);
            end
            check("out_ready", out_ready, (in_ready || (exp_q.size() < L)));
            if (exp_q.size() == 0) check("no_spurious_valid", out_valid, 1'b0);
            hold_chk = out_valid && !in_ready;
            held_c   = out_c;
            if (out_valid && in_ready && (exp_q.size() != 0)) begin
                e = exp_q.pop_front();
                check("data", out_c, e);
                check("unmasked", unmask(out_c), unmask(e));
            end
            if (in_valid && out_ready) exp_q.push_back(ref_result(in_a, in_b, in_random));
        end
    end

    // Scoreboard monitor for the plain one-stage pipe.
    always @(negedge in_clock) begin : mon_plain
        if (in_reset) begin
            p_exp_q.delete();
        end else begin
            check("plain_ready", p_out_ready, 1'b1);
            check("plain_valid", p_out_valid, (p_exp_q.size() != 0));
            if (p_out_valid && (p_exp_q.size() != 0)) check("plain_data", p_c, p_exp_q.pop_front());
            if (p_valid) p_exp_q.push_back(p_a ^ p_b);
        end
    end

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    // New random operands unless an offered input is still waiting for acceptance.
    task automatic drive(input bit want_valid, input bit rdy);
        if (!(in_valid && !fire_seen)) begin
            in_a      = m_sh_t'($urandom);
            in_b      = m_sh_t'($urandom);
            in_random = m_rnd_t'($urandom);
            in_valid  = want_valid;
        end
        in_ready = rdy;
        p_a      = 16'($urandom);
        p_b      = 16'($urandom);
        p_random = 8'($urandom);
        p_valid  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_reset = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
        in_a = '0; in_b = '0; in_random = '0;
        p_a = '0; p_b = '0; p_random = '0; p_valid = 1'b0;
        tick(); tick();
        @(negedge in_clock);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_c", out_c, 24'h0);
        check("rst_out_ready", out_ready, 1'b1);
        check("rst_plain_valid", p_out_valid, 1'b0);
        check("rst_plain_c", p_c, 16'h0);
        tick();
        in_reset = 1'b0;

        // Plain sharewise XOR, one stage.
        p_a = 16'h3C5A; p_b = 16'h0FF0; p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        @(negedge in_clock);
        check("plain_t1_c", p_c, 16'h33AA);
        check("plain_t1_unmasked", p_c[1] ^ p_c[0], 8'h99);
        tick();

        // Refreshed XOR with all-ones randomness, three stages.
        in_a = 24'h003C5A; in_b = 24'h000FF0; in_random = 16'hFFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        @(negedge in_clock);
        check("refresh_t2_c", out_c, 24'h00CC55);
        check("refresh_t2_unmasked", unmask(out_c), 8'h99);
        tick(); tick();

        // Back-to-back stream of 5: out_valid rises after the third edge.
        for (int i = 0; i < 7; i++) begin
            drive(i < 5, 1'b1);
            @(negedge in_clock);
            check("stream_valid", out_valid, (i >= 3));
            check("stream_ready", out_ready, 1'b1);
            tick();
        end

        // Fill under back-pressure, then hold it four more cycles.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0);
            @(negedge in_clock);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0);
            @(negedge in_clock);
            check("stall_out_ready", out_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1);
            @(negedge in_clock);
            tick();
        end

        // Full pipe: consume and accept in the same cycle, no bubble.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0);
            @(negedge in_clock);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            @(negedge in_clock);
            check("simul_out_ready", out_ready, 1'b1);
            check("simul_out_valid", out_valid, 1'b1);
            tick();
        end

        // Reset with results in flight and an input offered in the reset cycle.
        drive(1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b1);
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        in_valid = 1'b0;
        p_valid  = 1'b0;
        @(negedge in_clock);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_c", out_c, 24'h0);
        check("midrst_out_ready", out_ready, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge in_clock);
            check("midrst_no_ghost", out_valid, 1'b0);
            tick();
        end

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
            @(negedge in_clock);
            tick();
        end

        // Bounded drain.
        in_valid = (in_valid && !fire_seen);
        for (int i = 0; i < 30; i++) begin
            in_ready = 1'b1;
            p_valid  = 1'b0;
            if (!in_valid && exp_q.size() == 0) break;
            @(negedge in_clock);
            tick();
            if (fire_seen) in_valid = 1'b0;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
